relu_maxpool2x2: RTL and testbench

Streaming float16 ReLU and 2×2/stride-2 max-pool stage that sits directly downstream of `convUnit`. It consumes the unit's `result`/`cu_out_valid` stream, one output-map pixel per valid beat in raster order. It emits one pooled pixel per 2×2 window, so the pooled map is `map_width/2` × `map_height/2`. It holds one half-width row of partial maxima and has no backpressure.

---
 rtl/relu_maxpool2x2.sv | 88 ++++++++
 tb/tb_relu_maxpool2x2.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool2x2.sv
// Streaming float16 ReLU followed by 2x2/stride-2 max-pool over a raster-ordered map.
// Keeps one half-width row of partial maxima; no backpressure.
module relu_maxpool2x2 #(
    parameter int data_width = 16,
    parameter int map_width  = 24,
    parameter int map_height = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic                  out_last
);

    localparam int half_w = map_width / 2;
    localparam int col_w  = $clog2(map_width);
    localparam int row_w  = $clog2(map_height);
    localparam int idx_w  = (half_w > 1) ? $clog2(half_w) : 1;

    // After ReLU both sign bits are clear, so magnitude bits order the values.
    function automatic logic [data_width-1:0] fmax(input logic [data_width-1:0] a,
                                                   input logic [data_width-1:0] b);
        return (a[data_width-2:0] >= b[data_width-2:0]) ? a : b;
    endfunction

    logic [col_w-1:0]      col;
    logic [row_w-1:0]      row;
    logic [data_width-1:0] p;
    logic [data_width-1:0] rb [half_w];
    logic [idx_w-1:0]      rb_idx;
    logic [data_width-1:0] x;
    logic [data_width-1:0] rb_q;
    logic [data_width-1:0] pair_max;
    logic [data_width-1:0] win_max;
    logic                  col_last;
    logic                  row_last;

    always_comb begin
        x        = in_data[data_width-1] ? '0 : in_data;
        rb_idx   = idx_w'(col >> 1);
        rb_q     = rb[rb_idx];
        pair_max = fmax(p, x);
        win_max  = fmax(pair_max, rb_q);
        col_last = (col == col_w'(map_width - 1));
        row_last = (row == row_w'(map_height - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (in_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    p <= x;
                end else if (row[0]) begin
                    out_data  <= win_max;
                    out_valid <= 1'b1;
                    out_last  <= row_last && col_last;
                end
            end
        end
    end

    // NOTE: the row buffer is deliberately left without reset; every entry is written on an even row before its odd-row read.
    always_ff @(posedge clk) begin
        if (in_valid && col[0] && !row[0]) begin
            rb[rb_idx] <= pair_max;
        end
    end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2: a 4x4 instance and a 6x2 instance, every beat checked
// for exact output timing, value, out_last and hold behaviour.
module tb_relu_maxpool2x2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_in_valid, b_in_valid;
    logic [15:0] a_in_data, b_in_data;
    logic        a_out_valid, b_out_valid;
    logic [15:0] a_out_data, b_out_data;
    logic        a_out_last, b_out_last;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] held [2];

    always #5 clk = ~clk;

    relu_maxpool2x2 #(.data_width(16), .map_width(4), .map_height(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last)
    );

    relu_maxpool2x2 #(.data_width(16), .map_width(6), .map_height(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    endtask

    function automatic logic obs_valid(input bit sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction

    function automatic logic [15:0] obs_data(input bit sel);
        return sel ? b_out_data : a_out_data;
    endfunction

    function automatic logic obs_last(input bit sel);
        return sel ? b_out_last : a_out_last;
    endfunction

    // One accepted sample, then optional idle cycles; called and returns at a falling edge.
    task automatic beat(input bit sel, input logic [15:0] d, input logic exp_v,
                        input logic [15:0] exp_d, input logic exp_l, input int gap);
        if (sel) begin b_in_valid = 1'b1; b_in_data = d; end
        else     begin a_in_valid = 1'b1; a_in_data = d; end
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0; a_in_data = 16'h7BFF;
        b_in_valid = 1'b0; b_in_data = 16'h7BFF;
        check("out_valid", {15'd0, obs_valid(sel)}, {15'd0, exp_v});
        if (exp_v) begin
            check("out_data", obs_data(sel), exp_d);
            check("out_last", {15'd0, obs_last(sel)}, {15'd0, exp_l});
            held[sel] = exp_d;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            @(negedge clk);
            check("gap_valid", {15'd0, obs_valid(sel)}, 16'd0);
            check("gap_hold", obs_data(sel), held[sel]);
        end
    endtask

    task automatic send_map(input bit sel, input int w, input int h, input logic [15:0] pix[$],
                            input logic [15:0] exp_q[$], input int max_gap);
        for (int k = 0; k < w * h; k++) begin
            int   r    = k / w;
            int   c    = k % w;
            int   widx = (r / 2) * (w / 2) + c / 2;
            logic ev   = (r % 2 == 1) && (c % 2 == 1);
            int   gap  = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            beat(sel, pix[k], ev, ev ? exp_q[widx] : 16'h0000, k == w * h - 1, gap);
        end
    endtask

    initial begin
        logic [15:0] pix[$];
        logic [15:0] ex[$];
        reset = 1'b0;
        a_in_valid = 1'b0; a_in_data = 16'h0000;
        b_in_valid = 1'b0; b_in_data = 16'h0000;
        held[0] = 16'h0000; held[1] = 16'h0000;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", {15'd0, a_out_valid}, 16'd0);
        check("rst_last", {15'd0, a_out_last}, 16'd0);
        check("rst_data", a_out_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // All-ones map.
        pix = '{16{16'h3C00}};
        ex  = '{4{16'h3C00}};
        send_map(1'b0, 4, 4, pix, ex, 0);

        // Max sitting in a different corner of every window.
        pix = '{16'h3C00, 16'h4400, 16'h4400, 16'h4000,
                16'h4000, 16'h4200, 16'h4200, 16'h3C00,
                16'h4000, 16'h4200, 16'h4200, 16'h3C00,
                16'h3C00, 16'h4400, 16'h4400, 16'h4000};
        ex  = '{4{16'h4400}};
        send_map(1'b0, 4, 4, pix, ex, 0);

        // Same data with random idle gaps; junk on in_data while idle.
        send_map(1'b0, 4, 4, pix, ex, 3);

        // ReLU: negatives/-0/negative NaN clear, subnormal beats zero, +Inf and +NaN propagate.
        pix = '{16'hBC00, 16'h8000, 16'hBC00, 16'h0001,
                16'hC400, 16'hFE00, 16'h8000, 16'h0000,
                16'h7C00, 16'h3C00, 16'h7E00, 16'h7C00,
                16'hFC00, 16'h0000, 16'h0001, 16'h3C00};
        ex  = '{16'h0000, 16'h0001, 16'h7C00, 16'h7E00};
        send_map(1'b0, 4, 4, pix, ex, 0);

        // Reset mid-map: 7 samples (window 0 completes on the 6th), then a clean map.
        for (int k = 0; k < 7; k++) beat(1'b0, 16'h4500, k == 5, 16'h4500, 1'b0, 0);
        reset = 1'b1;
        #1;
        check("midrst_valid", {15'd0, a_out_valid}, 16'd0);
        check("midrst_data", a_out_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        held[0] = 16'h0000;
        pix = '{16{16'h4000}};
        ex  = '{4{16'h4000}};
        send_map(1'b0, 4, 4, pix, ex, 0);

        // Two back-to-back 6x2 maps.
        pix = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h4000, 16'h3C00,
                16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
        ex  = '{16'h4000, 16'h3C00, 16'h4000};
        send_map(1'b1, 6, 2, pix, ex, 0);
        pix = '{16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h3C00, 16'h3C00};
        ex  = '{16'h4000, 16'h4000, 16'h3C00};
        send_map(1'b1, 6, 2, pix, ex, 0);

        // Trailing idle cycles: no stray pulses.
        for (int g = 0; g < 3; g++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_valid_a", {15'd0, a_out_valid}, 16'd0);
            check("idle_valid_b", {15'd0, b_out_valid}, 16'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
